// File: rtl/collider_pkg.sv
// Shared grid geometry, neighbour offset table and scan FSM encoding for the
// calorimeter tower cluster scanner.
package collider_pkg;

  localparam int N_ETA = 32;
  localparam int N_PHI = 32;
  localparam int ETA_W = 5;
  localparam int PHI_W = 5;
  localparam int IDX_W = ETA_W + PHI_W;
  localparam int ET_W  = 10;
  localparam int SUM_W = 14;
  localparam int NBR_N = 8;
  localparam int NBR_W = 3;

  // Neighbour visiting order: the row below the seed, then the seed row, then the row above.
  localparam logic signed [1:0] NBR_DETA [NBR_N] = '{2'sb11, 2'sb00, 2'sb01, 2'sb11,
                                                      2'sb01, 2'sb11, 2'sb00, 2'sb01};
  localparam logic signed [1:0] NBR_DPHI [NBR_N] = '{2'sb11, 2'sb11, 2'sb11, 2'sb00,
                                                      2'sb00, 2'sb01, 2'sb01, 2'sb01};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED_RD,
    ST_SEED_WT,
    ST_NBR_RD,
    ST_NBR_WT,
    ST_EMIT,
    ST_ADV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tower_nbr_addr.sv
// Maps a seed position and neighbour number to the neighbour's grid address,
// with phi wrapping, eta bounded, and its raster order relative to the seed.
module tower_nbr_addr
  import collider_pkg::*;
(
  input  logic [ETA_W-1:0] seed_eta_i,
  input  logic [PHI_W-1:0] seed_phi_i,
  input  logic [NBR_W-1:0] nbr_sel_i,
  output logic [ETA_W-1:0] nbr_eta_o,
  output logic [PHI_W-1:0] nbr_phi_o,
  output logic             in_grid_o,
  output logic             precedes_o
);

  logic signed [1:0] deta;
  logic signed [1:0] dphi;
  logic [ETA_W+1:0]  eta_ext;

  assign deta = NBR_DETA[nbr_sel_i];
  assign dphi = NBR_DPHI[nbr_sel_i];

  // Two guard bits catch both -1 and 32 as off-grid.
  assign eta_ext   = {2'b00, seed_eta_i} + {{ETA_W{deta[1]}}, deta};
  assign in_grid_o = (eta_ext[ETA_W+1:ETA_W] == 2'b00);
  assign nbr_eta_o = eta_ext[ETA_W-1:0];

  assign nbr_phi_o  = seed_phi_i + {{(PHI_W-2){dphi[1]}}, dphi};
  assign precedes_o = ({nbr_phi_o, nbr_eta_o} < {seed_phi_i, seed_eta_i});

endmodule

// File: rtl/tower_cluster_scan.sv
// Raster-scans the unpacked tower grid, qualifies local-maximum seeds above
// threshold and streams one 3x3 cluster record per seed over valid/ready.
module tower_cluster_scan
  import collider_pkg::*;
#(
  parameter int SEED_THR = 20,
  parameter int MAX_CL   = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic             rd_en_o,
  output logic [ETA_W-1:0] rd_eta_o,
  output logic [PHI_W-1:0] rd_phi_o,
  input  logic [ET_W-1:0]  rd_et_i,
  output logic             cl_valid_o,
  input  logic             cl_ready_i,
  output logic [ETA_W-1:0] cl_eta_o,
  output logic [PHI_W-1:0] cl_phi_o,
  output logic [SUM_W-1:0] cl_et_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  localparam int               CNT_W    = $clog2(MAX_CL + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ETA * N_PHI - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBR_W-1:0] nbr_q, nbr_d;
  logic [ET_W-1:0]  seed_et_q, seed_et_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             lose_q, lose_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [ETA_W-1:0] last_eta_q;
  logic [PHI_W-1:0] last_phi_q;

  logic             rd_en;
  logic             nbr_fail;
  logic [ETA_W-1:0] seed_eta, nbr_eta, rd_eta;
  logic [PHI_W-1:0] seed_phi, nbr_phi, rd_phi;
  logic             nbr_in_grid, nbr_precedes;

  assign seed_eta = idx_q[ETA_W-1:0];
  assign seed_phi = idx_q[IDX_W-1:ETA_W];

  tower_nbr_addr u_nbr_addr (
    .seed_eta_i (seed_eta),
    .seed_phi_i (seed_phi),
    .nbr_sel_i  (nbr_q),
    .nbr_eta_o  (nbr_eta),
    .nbr_phi_o  (nbr_phi),
    .in_grid_o  (nbr_in_grid),
    .precedes_o (nbr_precedes)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nbr_d      = nbr_q;
    seed_et_d  = seed_et_q;
    sum_d      = sum_q;
    lose_d     = lose_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_en      = 1'b0;
    nbr_fail   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_SEED_RD;
          idx_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      ST_SEED_RD: begin
        rd_en   = 1'b1;
        state_d = ST_SEED_WT;
      end
      ST_SEED_WT: begin
        if (rd_et_i < ET_W'(SEED_THR)) begin
          state_d = ST_ADV;
        end else begin
          seed_et_d = rd_et_i;
          sum_d     = SUM_W'(rd_et_i);
          nbr_d     = '0;
          lose_d    = 1'b0;
          state_d   = ST_NBR_RD;
        end
      end
      ST_NBR_RD: begin
        rd_en   = nbr_in_grid;
        state_d = ST_NBR_WT;
      end
      ST_NBR_WT: begin
        // Ties go to the seed earlier in raster order.
        if (nbr_in_grid) begin
          sum_d    = sum_q + SUM_W'(rd_et_i);
          nbr_fail = nbr_precedes ? (seed_et_q <= rd_et_i) : (seed_et_q < rd_et_i);
        end
        lose_d = lose_q | nbr_fail;
        if (nbr_q == NBR_W'(NBR_N - 1)) begin
          if (lose_d) begin
            state_d = ST_ADV;
          end else if (count_q < CNT_W'(MAX_CL)) begin
            state_d = ST_EMIT;
          end else begin
            overflow_d = 1'b1;
            state_d    = ST_ADV;
          end
        end else begin
          nbr_d   = nbr_q + NBR_W'(1);
          state_d = ST_NBR_RD;
        end
      end
      ST_EMIT: begin
        if (cl_ready_i) begin
          count_d = count_q + CNT_W'(1);
          state_d = ST_ADV;
        end
      end
      ST_ADV: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SEED_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      nbr_q      <= '0;
      seed_et_q  <= '0;
      sum_q      <= '0;
      lose_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_eta_q <= '0;
      last_phi_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nbr_q      <= nbr_d;
      seed_et_q  <= seed_et_d;
      sum_q      <= sum_d;
      lose_q     <= lose_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (rd_en) begin
        last_eta_q <= rd_eta;
        last_phi_q <= rd_phi;
      end
    end
  end

  // The read address holds its last issued value between strobes.
  assign rd_eta   = (state_q == ST_SEED_RD) ? seed_eta : nbr_eta;
  assign rd_phi   = (state_q == ST_SEED_RD) ? seed_phi : nbr_phi;
  assign rd_en_o  = rd_en;
  assign rd_eta_o = rd_en ? rd_eta : last_eta_q;
  assign rd_phi_o = rd_en ? rd_phi : last_phi_q;

  assign cl_valid_o = (state_q == ST_EMIT);
  assign cl_eta_o   = seed_eta;
  assign cl_phi_o   = seed_phi;
  assign cl_et_o    = sum_q;
  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o     = (state_q == ST_DONE);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_tower_cluster_scan.sv
// Directed bench for tower_cluster_scan: the unpacker grid is a 1-cycle-latency
// RAM, and every expectation below is hand-computed from the grid contents.
module tb_tower_cluster_scan;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        rd_en_o;
  logic [4:0]  rd_eta_o;
  logic [4:0]  rd_phi_o;
  logic [9:0]  rd_et_i = '0;
  logic        cl_valid_o;
  logic        cl_ready_i;
  logic [4:0]  cl_eta_o;
  logic [4:0]  cl_phi_o;
  logic [13:0] cl_et_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  grid [0:1023];
  logic [23:0] rec_q [$];
  int          done_cnt = 0;

  always #5 clk_i = ~clk_i;

  tower_cluster_scan #(.SEED_THR(20), .MAX_CL(64)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .rd_en_o    (rd_en_o),
    .rd_eta_o   (rd_eta_o),
    .rd_phi_o   (rd_phi_o),
    .rd_et_i    (rd_et_i),
    .cl_valid_o (cl_valid_o),
    .cl_ready_i (cl_ready_i),
    .cl_eta_o   (cl_eta_o),
    .cl_phi_o   (cl_phi_o),
    .cl_et_o    (cl_et_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .overflow_o (overflow_o)
  );

  always @(posedge clk_i) begin
    if (rd_en_o) rd_et_i <= grid[{rd_phi_o, rd_eta_o}];
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (cl_valid_o && cl_ready_i) begin
        rec_q.push_back({cl_eta_o, cl_phi_o, cl_et_o});
        $display("record eta=%0d phi=%0d et=%0d", cl_eta_o, cl_phi_o, cl_et_o);
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rec(input int eta, input int phi, input int et);
    rec = {eta[4:0], phi[4:0], et[13:0]};
  endfunction

  task automatic clear_grid();
    for (int i = 0; i < 1024; i++) grid[i] = '0;
  endtask

  task automatic put(input int eta, input int phi, input int et);
    grid[phi * 32 + eta] = et[9:0];
  endtask

  // Returns the cycle number (1 = first cycle after the accept edge) in which done is seen.
  // A second start pulse mid-scan must be ignored.
  task automatic run_scan(input string tag, output int cyc);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    chk({tag, "_busy_on"}, busy_o, 1);
    while (!done_o && cyc < 10000) begin
      @(negedge clk_i);
      cyc++;
      start_i = (cyc == 100);
    end
    start_i = 1'b0;
    chk({tag, "_done_seen"}, done_o, 1);
    chk({tag, "_busy_at_done"}, busy_o, 0);
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_busy_after"}, busy_o, 0);
    $display("scan %s: done in cycle %0d", tag, cyc);
  endtask

  initial begin
    int cyc;
    int rb;
    int d0;
    int w;

    rst_ni     = 1'b0;
    start_i    = 1'b0;
    cl_ready_i = 1'b1;
    clear_grid();
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", {rd_en_o, cl_valid_o, busy_o, done_o, overflow_o}, 0);
    chk("rst_addr", {rd_eta_o, rd_phi_o, cl_eta_o, cl_phi_o}, 0);
    chk("rst_et", cl_et_o, 0);
    rst_ni = 1'b1;

    // 1: empty grid
    rb = rec_q.size(); d0 = done_cnt;
    run_scan("t1", cyc);
    chk("t1_cycles", cyc, 3073);
    chk("t1_records", rec_q.size() - rb, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_overflow", overflow_o, 0);

    // 2: single tower plus a just-below-threshold tower
    clear_grid(); put(10, 5, 100); put(20, 20, 19);
    rb = rec_q.size(); d0 = done_cnt;
    run_scan("t2", cyc);
    chk("t2_cycles", cyc, 3090);
    chk("t2_records", rec_q.size() - rb, 1);
    if (rec_q.size() > rb) chk("t2_rec", rec_q[rb], rec(10, 5, 100));
    chk("t2_done_cnt", done_cnt - d0, 1);

    // 3: phi wrap and both eta edges (no eta wrap)
    clear_grid(); put(4, 31, 50); put(4, 0, 30); put(0, 10, 60); put(31, 12, 70); put(0, 12, 5);
    rb = rec_q.size();
    run_scan("t3", cyc);
    chk("t3_cycles", cyc, 3140);
    chk("t3_records", rec_q.size() - rb, 3);
    if (rec_q.size() >= rb + 3) begin
      chk("t3_rec0", rec_q[rb],     rec(0, 10, 60));
      chk("t3_rec1", rec_q[rb + 1], rec(31, 12, 70));
      chk("t3_rec2", rec_q[rb + 2], rec(4, 31, 80));
    end

    // 4: equal neighbours, earlier one wins
    clear_grid(); put(3, 3, 40); put(4, 3, 40);
    rb = rec_q.size();
    run_scan("t4", cyc);
    chk("t4_cycles", cyc, 3106);
    chk("t4_records", rec_q.size() - rb, 1);
    if (rec_q.size() > rb) chk("t4_rec", rec_q[rb], rec(3, 3, 80));

    // 5: backpressure for 10 cycles during EMIT
    clear_grid(); put(10, 5, 100);
    rb = rec_q.size();
    cl_ready_i = 1'b0;
    fork
      run_scan("t5", cyc);
      begin
        w = 0;
        while (!cl_valid_o && w < 10000) begin
          @(negedge clk_i);
          w++;
        end
        chk("t5_valid", cl_valid_o, 1);
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk_i);
          chk("t5_hold", {cl_valid_o, rd_en_o, cl_eta_o, cl_phi_o, cl_et_o}, {2'b10, rec(10, 5, 100)});
        end
        cl_ready_i = 1'b1;
      end
    join
    chk("t5_cycles", cyc, 3100);
    chk("t5_records", rec_q.size() - rb, 1);
    if (rec_q.size() > rb) chk("t5_rec", rec_q[rb], rec(10, 5, 100));

    // 6: 70 isolated seeds against a 64-record limit, then reset mid-scan
    clear_grid();
    for (int k = 0; k < 70; k++) put(1 + 3 * (k % 10), 1 + 3 * (k / 10), 20 + k);
    rb = rec_q.size(); d0 = done_cnt;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    w = 0;
    while (!overflow_o && w < 20000) begin
      @(negedge clk_i);
      w++;
    end
    chk("t6_overflow", overflow_o, 1);
    chk("t6_busy_at_ovf", busy_o, 1);
    chk("t6_records", rec_q.size() - rb, 64);
    for (int k = 0; k < 64; k++) begin
      if (rec_q.size() > rb + k)
        chk($sformatf("t6_rec%0d", k), rec_q[rb + k], rec(1 + 3 * (k % 10), 1 + 3 * (k / 10), 20 + k));
    end
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_ctrl", {rd_en_o, cl_valid_o, busy_o, done_o, overflow_o}, 0);
    chk("t6_rst_addr", {rd_eta_o, rd_phi_o, cl_eta_o, cl_phi_o}, 0);
    chk("t6_rst_et", cl_et_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3200) @(negedge clk_i);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_idle_busy", busy_o, 0);
    chk("t6_records_final", rec_q.size() - rb, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
